mp_shared_mem_arbiter: RTL and testbench
========================================

Name: mp_shared_mem_arbiter

Overview:
- Parametrised shared data-memory port for the multiprocessor. Replaces the fixed three-core memory path.
- N_CORES request channels are served by round-robin arbitration. Each granted channel gets one read or write per cycle into an internal DATA_W x MEM_DEPTH array.
- Sits between the per-core execute stages and the shared memory. A debug read port exposes memory contents to the testbench monitor, as mem_out does today.

Parameters:
- N_CORES, 4, number of requesting cores (2..8).
- DATA_W, 8, data word width.
- ADDR_W, 8, address width per request.
- MEM_DEPTH, 256, number of words; must be <= 2**ADDR_W.
- CNT_W, 16, width of the grant counter.

Ports:
- clk  in  1  system clock, all state on posedge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  N_CORES  per-core access request, level.
- we  in  N_CORES  per-core write enable (1=write, 0=read), valid with req.
- addr  in  N_CORES*ADDR_W  per-core address, core i at [i*ADDR_W +: ADDR_W].
- wdata  in  N_CORES*DATA_W  per-core write data, same packing.
- gnt  out  N_CORES  one-hot grant pulse, registered.
- rdata  out  DATA_W  read data for the granted read, registered.
- rvalid  out  1  rdata valid this cycle.
- err  out  1  pulse: granted access addressed >= MEM_DEPTH.
- dbg_addr  in  ADDR_W  debug read address.
- dbg_data  out  DATA_W  combinational mem[dbg_addr]; 0 if out of range.
- grant_cnt  out  CNT_W  total grants since reset, saturating.

Behaviour:
- Reset (rst_n low, asynchronous): gnt=0, rvalid=0, rdata=0, err=0, grant_cnt=0, rr_ptr=0, all memory words cleared to 0.
- Reset asserted mid-access aborts it: no write lands after reset assertion; outputs are forced to reset values immediately.
- Arbitration at each posedge:
  - Search req starting at index rr_ptr, wrapping modulo N_CORES. First set bit i wins.
  - Next cycle: gnt[i]=1, all other bits 0.
  - rr_ptr <= (i+1) mod N_CORES. No request: rr_ptr holds and gnt=0.
- The access executes on the same edge that registers gnt:
  - write: mem[addr_i] <= wdata_i; rvalid=0.
  - read: rdata <= mem[addr_i] (pre-edge contents); rvalid=1.
- Latency: a request seen at edge k gets gnt/rvalid/rdata during cycle k..k+1. One access total per cycle.
- Requester handshake:
  - Hold req/we/addr/wdata stable until gnt[i] is observed high.
  - If req[i] is still high at the edge ending the gnt cycle, it is a new request and is arbitrated normally. Because of rotation, other waiting cores win first.
- Fairness: with all N_CORES requesting continuously, each core is granted exactly once per N_CORES cycles. Maximum wait is N_CORES-1 cycles.
- Out of range (addr_i >= MEM_DEPTH):
  - Grant is still issued and counted; err=1 for that cycle.
  - Write is dropped. Read returns rdata=0 with rvalid=1.
- rdata holds its last value when rvalid=0.
- grant_cnt increments by 1 per grant and saturates at all-ones.
- dbg_data reads the array combinationally. A write at edge k is visible on dbg_data after edge k; same-cycle debug read of a written address returns the old value.
- No state machine beyond rr_ptr. The block is pipelined one stage: request -> registered grant/response.

Test Plan:
- Reset then idle:
  - Stimulus: rst_n low 3 cycles, release, req=0 for 5 cycles.
  - Required: gnt=0, rvalid=0, rdata=0, grant_cnt=0, dbg_data=0 at dbg_addr=0x10.
- Single write/read:
  - Stimulus: core 2 writes 0xA5 to 0x10, then reads 0x10.
  - Required: gnt=4'b0100 on each, 1-cycle latency; read gives rdata=0xA5, rvalid=1; dbg_data(0x10)=0xA5; grant_cnt=2.
- Round-robin:
  - Stimulus: all 4 cores hold req high for 8 cycles.
  - Required: gnt sequence 0001, 0010, 0100, 1000, 0001, ...; grant_cnt=8.
- Wrap and priority after grant:
  - Stimulus: last grant to core 3, then req=4'b1001.
  - Required: core 0 granted first, then core 3.
- Out of range with MEM_DEPTH=200:
  - Stimulus: core 1 writes 0x77 to addr 220, then reads 220.
  - Required: err=1 both cycles, read gives rdata=0 with rvalid=1, memory unchanged.
- Reset mid-stream:
  - Stimulus: rst_n pulled low while core 0 write of 0x3C to 0x05 is pending.
  - Required: gnt drops immediately; mem[0x05]=0 after release; rr_ptr restarts at 0.

Source files
------------

// File: rtl/mp_shared_mem_arbiter.sv
// rtl/mp_shared_mem_arbiter.sv - round-robin arbitrated shared data memory for N cores
//
// Purpose:
//   N_CORES request channels share one DATA_W x MEM_DEPTH memory array. A
//   round-robin arbiter picks one requester per cycle. The access runs on the
//   same edge that registers the one-hot grant, so the block is a single
//   pipeline stage: request -> registered grant/response.
//
// Ports:
//   clk, rst_n     clock (posedge) and asynchronous active-low reset
//   req, we        per-core request level and write enable (1=write)
//   addr, wdata    per-core address/write data, core i at [i*W +: W]
//   gnt            registered one-hot grant pulse
//   rdata, rvalid  registered read data and its valid strobe
//   err            pulse: granted access addressed >= MEM_DEPTH
//   dbg_addr       debug read address
//   dbg_data       combinational mem[dbg_addr], 0 when out of range
//   grant_cnt      saturating count of grants since reset
module mp_shared_mem_arbiter #(
  parameter int N_CORES   = 4,
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int MEM_DEPTH = 256,
  parameter int CNT_W     = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_CORES-1:0]          req,
  input  logic [N_CORES-1:0]          we,
  input  logic [N_CORES*ADDR_W-1:0]   addr,
  input  logic [N_CORES*DATA_W-1:0]   wdata,
  output logic [N_CORES-1:0]          gnt,
  output logic [DATA_W-1:0]           rdata,
  output logic                        rvalid,
  output logic                        err,
  input  logic [ADDR_W-1:0]           dbg_addr,
  output logic [DATA_W-1:0]           dbg_data,
  output logic [CNT_W-1:0]            grant_cnt
);

  localparam int PTR_W  = (N_CORES > 1) ? $clog2(N_CORES) : 1;
  localparam int MEM_AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [N_CORES-1:0] gnt_q, gnt_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic               rvalid_q, rvalid_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  mem_q [MEM_DEPTH];

  logic               found;
  logic [PTR_W-1:0]   win;
  int                 idx;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_wdata;
  logic               sel_we;
  logic               in_range;
  logic               mem_wr;
  logic [MEM_AW-1:0]  mem_idx;
  logic               dbg_in_range;
  logic [MEM_AW-1:0]  dbg_idx;

  // Round-robin search: scan starting at rr_ptr, wrapping modulo N_CORES;
  // the first asserted request wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 0; k < N_CORES; k++) begin
      idx = (int'(rr_ptr_q) + k) % N_CORES;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx[PTR_W-1:0];
      end
    end
  end

  // Steer the winner's request fields onto the single memory port.
  always_comb begin
    sel_addr  = addr[win*ADDR_W +: ADDR_W];
    sel_wdata = wdata[win*DATA_W +: DATA_W];
    sel_we    = we[win];
    in_range  = (int'(sel_addr) < MEM_DEPTH);
    mem_idx   = in_range ? sel_addr[MEM_AW-1:0] : '0;
    mem_wr    = found && sel_we && in_range;
  end

  always_comb begin
    gnt_d    = '0;
    rr_ptr_d = rr_ptr_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    err_d    = 1'b0;
    cnt_d    = cnt_q;
    if (found) begin
      gnt_d[win] = 1'b1;
      rr_ptr_d   = (int'(win) == N_CORES - 1) ? '0 : win + 1'b1;
      err_d      = !in_range;
      if (cnt_q != {CNT_W{1'b1}}) begin
        cnt_d = cnt_q + 1'b1;
      end
      if (!sel_we) begin
        // Out-of-range reads still complete, returning zero.
        rdata_d  = in_range ? mem_q[mem_idx] : '0;
        rvalid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
      gnt_q    <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      gnt_q    <= gnt_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  // The array is cleared by reset so a write pending when reset asserts
  // can never land.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < MEM_DEPTH; j++) begin
        mem_q[j] <= '0;
      end
    end else if (mem_wr) begin
      mem_q[mem_idx] <= sel_wdata;
    end
  end

  always_comb begin
    dbg_in_range = (int'(dbg_addr) < MEM_DEPTH);
    dbg_idx      = dbg_in_range ? dbg_addr[MEM_AW-1:0] : '0;
    dbg_data     = dbg_in_range ? mem_q[dbg_idx] : '0;
  end

  assign gnt       = gnt_q;
  assign rdata     = rdata_q;
  assign rvalid    = rvalid_q;
  assign err       = err_q;
  assign grant_cnt = cnt_q;

endmodule

// File: tb/tb_mp_shared_mem_arbiter.sv
// tb/tb_mp_shared_mem_arbiter.sv - directed self-checking bench for mp_shared_mem_arbiter
module tb_mp_shared_mem_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int AW = 8;
  localparam int CW = 16;

  logic          clk;
  logic          rst_n;
  logic [N-1:0]  req;
  logic [N-1:0]  we;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] wdata;
  logic [N-1:0]  gnt;
  logic [DW-1:0] rdata;
  logic          rvalid;
  logic          err;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_data;
  logic [CW-1:0] grant_cnt;

  int n_cmp;
  int n_err;

  mp_shared_mem_arbiter #(
    .N_CORES(N), .DATA_W(DW), .ADDR_W(AW), .MEM_DEPTH(200), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .rdata(rdata), .rvalid(rvalid), .err(err),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data), .grant_cnt(grant_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock edge; outputs are then sampled at the following negedge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [3:0] rr_exp [8];
    rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    n_cmp = 0; n_err = 0;
    rst_n = 1'b0; req = '0; we = '0; addr = '0; wdata = '0; dbg_addr = 8'h10;

    // Reset then idle
    repeat (3) @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'h0);
    rst_n = 1'b1;
    repeat (5) step();
    chk("idle_gnt", 32'(gnt), 32'h0);
    chk("idle_rvalid", 32'(rvalid), 32'h0);
    chk("idle_rdata", 32'(rdata), 32'h0);
    chk("idle_cnt", 32'(grant_cnt), 32'h0);
    chk("idle_dbg", 32'(dbg_data), 32'h0);

    // Core 2 writes 0xA5 to 0x10, then reads it back
    req = 4'b0100; we = 4'b0100; addr[2*AW +: AW] = 8'h10; wdata[2*DW +: DW] = 8'hA5;
    chk("wr_dbg_pre", 32'(dbg_data), 32'h0);
    step();
    chk("wr_gnt", 32'(gnt), 32'h4);
    chk("wr_rvalid", 32'(rvalid), 32'h0);
    chk("wr_err", 32'(err), 32'h0);
    chk("wr_dbg", 32'(dbg_data), 32'hA5);
    we = 4'b0000;
    step();
    chk("rd_gnt", 32'(gnt), 32'h4);
    chk("rd_rvalid", 32'(rvalid), 32'h1);
    chk("rd_rdata", 32'(rdata), 32'hA5);
    chk("rd_cnt", 32'(grant_cnt), 32'h2);
    req = '0;
    step();
    chk("hold_gnt", 32'(gnt), 32'h0);
    chk("hold_rvalid", 32'(rvalid), 32'h0);
    chk("hold_rdata", 32'(rdata), 32'hA5);

    // Fresh reset so rotation starts at core 0, then all cores request
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    addr = '0; req = 4'b1111; we = 4'b0000;
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("rr_gnt%0d", i), 32'(gnt), 32'(rr_exp[i]));
    end
    chk("rr_cnt", 32'(grant_cnt), 32'd8);

    // Last grant went to core 3: core 0 wins first, then core 3
    req = 4'b1001;
    step();
    chk("wrap_gnt0", 32'(gnt), 32'h1);
    step();
    chk("wrap_gnt1", 32'(gnt), 32'h8);
    req = '0;
    step();

    // Core 1 stores a known value so a zeroed out-of-range read is visible
    req = 4'b0010; we = 4'b0010; addr[1*AW +: AW] = 8'h20; wdata[1*DW +: DW] = 8'h5A;
    step();
    we = 4'b0000;
    step();
    chk("c1_rdata", 32'(rdata), 32'h5A);
    chk("c1_err", 32'(err), 32'h0);

    // Out of range: core 1 writes 0x77 to 220, then reads 220
    we = 4'b0010; addr[1*AW +: AW] = 8'd220; wdata[1*DW +: DW] = 8'h77;
    step();
    chk("oor_wr_gnt", 32'(gnt), 32'h2);
    chk("oor_wr_err", 32'(err), 32'h1);
    chk("oor_wr_rvalid", 32'(rvalid), 32'h0);
    we = 4'b0000;
    step();
    chk("oor_rd_err", 32'(err), 32'h1);
    chk("oor_rd_rvalid", 32'(rvalid), 32'h1);
    chk("oor_rd_rdata", 32'(rdata), 32'h0);
    req = '0;
    step();
    chk("oor_err_clr", 32'(err), 32'h0);
    dbg_addr = 8'd220;
    #1 chk("oor_dbg220", 32'(dbg_data), 32'h0);
    dbg_addr = 8'd20;
    #1 chk("oor_dbg20", 32'(dbg_data), 32'h0);
    dbg_addr = 8'h20;
    #1 chk("oor_dbg_keep", 32'(dbg_data), 32'h5A);
    dbg_addr = 8'h10;
    #1 chk("oor_cnt", 32'(grant_cnt), 32'd14);

    // Reset mid-stream: gnt high from a core 2 read, core 0 write pending
    @(negedge clk);
    req = 4'b0100; we = 4'b0000; addr[2*AW +: AW] = 8'h10;
    step();
    chk("pre_rst_gnt", 32'(gnt), 32'h4);
    req = 4'b0001; we = 4'b0001; addr[0 +: AW] = 8'h05; wdata[0 +: DW] = 8'h3C;
    dbg_addr = 8'h05;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_gnt", 32'(gnt), 32'h0);
    chk("mid_rst_rvalid", 32'(rvalid), 32'h0);
    chk("mid_rst_cnt", 32'(grant_cnt), 32'h0);
    @(posedge clk);
    @(negedge clk);
    req = '0; we = '0;
    rst_n = 1'b1;
    #1 chk("mid_rst_mem", 32'(dbg_data), 32'h0);
    @(negedge clk);
    req = 4'b1111;
    step();
    chk("rst_rr_gnt0", 32'(gnt), 32'h1);
    step();
    chk("rst_rr_gnt1", 32'(gnt), 32'h2);
    req = '0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
